// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and operand-usage helpers
// for the RV32I pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_FAULT    = 2'd3
  } ctrl_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] ex_op,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = uses_rs1(id_op) && (ex_rd == id_rs1);
  assign hit_rs2  = uses_rs2(id_op) && (ex_rd == id_rs2);
  assign load_use = (ex_op == OPC_LOAD) && (ex_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: memory-wait holds, redirect flushes, load-use bubbles
// and a sticky data-memory timeout fault.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] id_op,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [6:0] ex_op,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_sel,
  output logic       hold_pc,
  output logic       hold_ifid,
  output logic       hold_idex,
  output logic       hold_exmem,
  output logic       bubble_ifid,
  output logic       bubble_idex,
  output logic       bubble_memwb,
  output logic [1:0] ctrl_state,
  output logic       mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              redirect_pending, redirect_pending_nxt;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall  = dmem_req && !dmem_ready;
  assign ctrl_state = state;

  load_use_detect u_load_use_detect (
    .id_op    (id_op),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .ex_op    (ex_op),
    .ex_rd    (ex_rd),
    .load_use (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= CTRL_RUN;
      wait_cnt         <= '0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_nxt;
      wait_cnt         <= wait_cnt_nxt;
      redirect_pending <= redirect_pending_nxt;
    end
  end

  always_comb begin
    state_nxt            = state;
    wait_cnt_nxt         = wait_cnt;
    redirect_pending_nxt = redirect_pending;
    pc_sel               = 1'b0;
    hold_pc              = 1'b0;
    hold_ifid            = 1'b0;
    hold_idex            = 1'b0;
    hold_exmem           = 1'b0;
    bubble_ifid          = 1'b0;
    bubble_idex          = 1'b0;
    bubble_memwb         = 1'b0;
    mem_timeout          = 1'b0;

    if (state == CTRL_FAULT) begin
      hold_pc      = 1'b1;
      hold_ifid    = 1'b1;
      hold_idex    = 1'b1;
      hold_exmem   = 1'b1;
      bubble_memwb = 1'b1;
      mem_timeout  = 1'b1;
    end else if (mem_stall) begin
      // A pending redirect or load-use simply waits: EX/ID are frozen.
      hold_pc      = 1'b1;
      hold_ifid    = 1'b1;
      hold_idex    = 1'b1;
      hold_exmem   = 1'b1;
      bubble_memwb = 1'b1;
      wait_cnt_nxt = wait_cnt + 1'b1;
      state_nxt    = (wait_cnt == WAIT_LAST) ? CTRL_FAULT : CTRL_MEM_WAIT;
    end else begin
      wait_cnt_nxt = '0;
      state_nxt    = CTRL_RUN;
      if (ex_branch_taken) begin
        pc_sel               = 1'b1;
        bubble_ifid          = 1'b1;
        bubble_idex          = 1'b1;
        redirect_pending_nxt = 1'b1;
      end else if (redirect_pending) begin
        // Synchronous imem still delivers the wrong-path word this cycle.
        bubble_ifid          = 1'b1;
        redirect_pending_nxt = 1'b0;
      end else if (load_use) begin
        hold_pc     = 1'b1;
        hold_ifid   = 1'b1;
        bubble_idex = 1'b1;
      end
    end

    if (rst) begin
      pc_sel       = 1'b0;
      hold_pc      = 1'b0;
      hold_ifid    = 1'b0;
      hold_idex    = 1'b0;
      hold_exmem   = 1'b0;
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_memwb = 1'b1;
      mem_timeout  = 1'b0;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It takes load-use conditions from ID/EX, branch/jump redirects resolved in EX, and the data-memory handshake from MEM, and drives per-register hold and bubble controls plus the PC redirect select. A watchdog latches a sticky fault on data-memory timeout. Non-load RAW hazards are left to the forwarding path and are not handled here.

## Interface
- MAX_WAIT, 16, consecutive data-memory stall cycles tolerated before fault; legal range 2..255
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous and active-high
- id_op  in  7  opcode of instruction in ID
- id_rs1, id_rs2  in  5  source registers of ID instruction
- ex_op  in  7  opcode of instruction in EX
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  EX resolved taken branch, JAL or JALR
- dmem_req  in  1  MEM stage holds LOAD/STORE
- dmem_ready  in  1  data memory completes the access this cycle
- pc_sel  out  1  PC loads EX redirect target
- hold_pc, hold_ifid, hold_idex, hold_exmem  out  1 each  register keeps its value
- bubble_ifid, bubble_idex, bubble_memwb  out  1 each  register loads NOP (addi x0,x0,0)
- ctrl_state  out  2  FSM state, debug
- mem_timeout  out  1  sticky fault flag

## Operation
- Registered state: FSM {RUN=0, MEM_WAIT=1, FAULT=3}, wait_cnt ($clog2(MAX_WAIT+1) bits), redirect_pending (1 bit). All outputs are combinational from state and inputs (Mealy).
- mem_stall = dmem_req & ~dmem_ready.
- load_use = (ex_op==`LOAD) & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
- Per-cycle priority in RUN/MEM_WAIT, first match wins:
  1. mem_stall: hold_pc, hold_ifid, hold_idex, hold_exmem, bubble_memwb. Redirect and load-use are deferred; redirect_pending is unchanged.
  2. ex_branch_taken: pc_sel, bubble_ifid, bubble_idex. Set redirect_pending.
  3. redirect_pending: bubble_ifid only, then clear redirect_pending. The synchronous imem returns the old-PC instruction one cycle after a redirect.
  4. load_use: hold_pc, hold_ifid, bubble_idex.
  5. Otherwise all controls are 0.
- FSM transitions and counter:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on the first cycle without mem_stall. That cycle is evaluated with priorities 2–5.
  - wait_cnt increments on each mem_stall cycle and clears on any non-stall cycle.
  - mem_stall with wait_cnt==MAX_WAIT-1 → next state FAULT.
- FAULT:
  - All holds = 1, bubble_memwb = 1, mem_timeout = 1.
  - pc_sel, bubble_ifid and bubble_idex = 0.
  - Exits only on rst.
- A new ex_branch_taken while redirect_pending is set takes priority 2 and re-arms the flag.

## Timing
- While rst=1: state RUN, wait_cnt 0, redirect_pending 0, mem_timeout 0; all bubble_* = 1; holds, pc_sel = 0.
- rst asserted mid-stall or in FAULT clears immediately, with no clock needed.
- Zero-latency controls: a redirect at cycle t gives pc_sel at t, bubble_ifid at t and t+1. Target fetch reaches ID at t+2.
- Load-use costs exactly one bubble. In the following cycle the load is in MEM and EX holds a NOP, so there is no re-detection.
- A dmem_ready arriving in the same cycle that wait_cnt==MAX_WAIT-1 is not a stall, so no fault.
- Fault is entered after exactly MAX_WAIT consecutive stall cycles. mem_timeout rises in cycle MAX_WAIT+1.
- A redirect coinciding with mem_stall is held: ex_branch_taken stays asserted because EX is held, and the redirect acts in the first ready cycle.

## Structure
- Shared defines header (existing opcode macros): `LUI, `AUIPC, `JAL, `JALR, `BRANCH, `LOAD, `STORE, `OP_IMM, `OP. Add the FSM encodings CTRL_RUN, CTRL_MEM_WAIT, CTRL_FAULT.
- One sub-module: load_use_detect, combinational, producing load_use from id_op/id_rs1/id_rs2/ex_op/ex_rd.
- Top level holds the FSM, wait_cnt, redirect_pending and the priority encoder.

## Test plan
- Reset: rst=1 mid-run → bubble_ifid/idex/memwb=1, holds=0, ctrl_state=0, mem_timeout=0; release → all controls 0 with idle inputs.
- Load-use: ex_op=LOAD, ex_rd=5, id_op=OP, id_rs2=5 → hold_pc, hold_ifid, bubble_idex for 1 cycle. Repeat with ex_rd=0, and with id_op=LUI, id_rs1=5 → no stall.
- Redirect: ex_branch_taken at t → pc_sel, bubble_ifid, bubble_idex at t; only bubble_ifid at t+1; all 0 at t+2.
- Mem wait: dmem_req=1, dmem_ready=0 for 3 cycles, MAX_WAIT=16 → 4 holds + bubble_memwb for 3 cycles, ctrl_state=1; ready → RUN, wait_cnt=0.
- Timeout: MAX_WAIT=4, ready never → ctrl_state=3 and mem_timeout=1 after 4 stall cycles, persisting despite ready. Async rst → cleared. Ready on the 4th cycle → no fault.
- Collision: ex_branch_taken and mem_stall at t, ready at t+2 → pc_sel only at t+2, bubble_ifid at t+3.
